// File: rtl/call_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : call_stack_ctrl
// Brief    : Call/return sequencer driving push/pop strobes of a return stack.
// Revision : 1.0
// ============================================================================
module call_stack_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 10,
  parameter int unsigned PTR_W      = 4,
  parameter int unsigned RET_OFFSET = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             call_req,
  input  logic             ret_req,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] stk_top,
  output logic [WIDTH-1:0] stk_dado,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] ret_addr,
  output logic             ret_valid,
  output logic             busy,
  output logic [PTR_W-1:0] depth,
  output logic             ovrflw_err,
  output logic             undrflw_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CALL     = 3'd1;
  localparam logic [2:0] S_RET_RD   = 3'd2;
  localparam logic [2:0] S_RET_DONE = 3'd3;
  localparam logic [2:0] S_ERR      = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] dado_q, dado_d;
  logic [WIDTH-1:0] ret_addr_q, ret_addr_d;
  logic [PTR_W-1:0] depth_q, depth_d;
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full, empty;

  assign full  = (depth_q == PTR_W'(DEPTH));
  assign empty = (depth_q == '0);

  // State and all outputs are registered together so every port is a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      dado_q     <= '0;
      ret_addr_q <= '0;
      depth_q    <= '0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dado_q     <= dado_d;
      ret_addr_q <= ret_addr_d;
      depth_q    <= depth_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (call_req)     state_d = full  ? S_ERR : S_CALL;
        else if (ret_req) state_d = empty ? S_ERR : S_RET_RD;
      end
      S_CALL:     state_d = S_IDLE;
      S_RET_RD:   state_d = S_RET_DONE;
      S_RET_DONE: state_d = S_IDLE;
      S_ERR:      state_d = S_ERR;
      default:    state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state.
  always_comb begin
    push_d     = (state_d == S_CALL);
    pop_d      = (state_d == S_RET_RD);
    valid_d    = (state_d == S_RET_DONE);
    busy_d     = (state_d != S_IDLE);
    dado_d     = dado_q;
    ret_addr_d = ret_addr_q;
    depth_d    = depth_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (state_q == S_IDLE) begin
      if (call_req) begin
        if (full) ovf_d  = 1'b1;
        else      dado_d = pc + WIDTH'(RET_OFFSET);
      end else if (ret_req && empty) begin
        unf_d = 1'b1;
      end
    end
    if (state_q == S_CALL)   depth_d = depth_q + PTR_W'(1);
    if (state_q == S_RET_RD) begin
      ret_addr_d = stk_top;
      depth_d    = depth_q - PTR_W'(1);
    end
  end

  assign stk_dado    = dado_q;
  assign stk_push    = push_q;
  assign stk_pop     = pop_q;
  assign ret_addr    = ret_addr_q;
  assign ret_valid   = valid_q;
  assign busy        = busy_q;
  assign depth       = depth_q;
  assign ovrflw_err  = ovf_q;
  assign undrflw_err = unf_q;

endmodule
`default_nettype wire
